// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM encoding, datapath width, the default
// bubble word and the IF/ID pipeline bundle.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } ifid_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus: instruction memory port plus the IF/ID handshake toward
// decode. master = fetch stage, slave = memory/decode side.
interface ifetch_stage_if;
   import core_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_instr;
   logic            stall;
   logic            flush;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc_plus4;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  stall,
      input  flush,
      output if_valid,
      output if_instr,
      output if_pc,
      output if_pc_plus4
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output stall,
      output flush,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      input  if_pc_plus4
   );

endinterface

// File: rtl/ifetch_pc_reg.sv
// Program counter with next-PC mux. With IFETCH_PC_DUP_EN a lockstep shadow
// PC runs its own copy of the mux and any divergence latches dup_err.
module ifetch_pc_reg
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_redirect,
   input  logic            advance,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc,
   output logic            dup_err
`ifdef IFETCH_PC_DUP_EN
   ,
   input  logic [XLEN-1:0] fault
`endif
);

   logic [XLEN-1:0] pc_p0;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] cur);
      if (load_redirect) return target;
      else if (advance)  return cur + XLEN'(4);
      else               return cur;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_p0 <= RESET_PC;
      else     pc_p0 <= next_pc(pc_p0);
   end

   assign pc = pc_p0;

`ifdef IFETCH_PC_DUP_EN
   logic [XLEN-1:0] shadow_p0;
   logic            dup_q;

   // Shadow advances from its own value so a single upset persists.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_p0 <= RESET_PC;
         dup_q     <= 1'b0;
      end else begin
         shadow_p0 <= next_pc(shadow_p0) ^ fault;
         dup_q     <= dup_q | (pc_p0 != shadow_p0);
      end
   end

   assign dup_err = dup_q;
`else
   assign dup_err = 1'b0;
`endif

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: BOOT/FETCH/HALTED control, IF/ID register and
// fetch counter. Optional PC lockstep check under IFETCH_PC_DUP_EN.
module ifetch_stage
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   ifetch_stage_if.master  bus,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req,
   output logic            halted,
   output logic            misalign_err,
   output logic            pc_dup_err,
   output logic [XLEN-1:0] fetch_count
`ifdef IFETCH_PC_DUP_EN
   ,
   input  logic [XLEN-1:0] pc_fault
`endif
);

   fetch_state_t    state_q, state_d;
   logic            pc_redirect, pc_advance;
   logic            ifid_load, ifid_bubble, misalign_set;
   logic [XLEN-1:0] pc_p0;
   ifid_t           ifid_p1;
   logic [XLEN-1:0] count_q;
   logic            misalign_q;

   ifetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk           (clk),
      .rst           (rst),
      .load_redirect (pc_redirect),
      .advance       (pc_advance),
      .target        (word_align(redirect_pc)),
      .pc            (pc_p0),
      .dup_err       (pc_dup_err)
`ifdef IFETCH_PC_DUP_EN
      ,
      .fault         (pc_fault)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= BOOT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      pc_redirect = 1'b0;
      pc_advance  = 1'b0;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            // redirect > flush > stall > halt > normal fetch
            if (redirect_valid) begin
               pc_redirect = 1'b1;
               ifid_bubble = 1'b1;
            end else if (bus.flush) begin
               ifid_bubble = 1'b1;
            end else if (!bus.stall) begin
               if (halt_req) begin
                  ifid_bubble = 1'b1;
                  state_d     = HALTED;
               end else begin
                  ifid_load  = 1'b1;
                  pc_advance = 1'b1;
               end
            end
         end
         HALTED: begin
            ifid_bubble = 1'b1;
            pc_redirect = redirect_valid;
            if (!halt_req) state_d = FETCH;
         end
         default: state_d = BOOT;
      endcase
      misalign_set = pc_redirect && (redirect_pc[1:0] != 2'b00);
   end

   // ---- stage boundary: PC (p0) -> IF/ID (p1) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_p1 <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      end else if (ifid_load) begin
         ifid_p1 <= '{valid: 1'b1, instr: bus.imem_instr, pc: pc_p0,
                      pc_plus4: pc_p0 + XLEN'(4)};
      end else if (ifid_bubble) begin
         ifid_p1.valid <= 1'b0;
         ifid_p1.instr <= NOP_INSTR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         if (ifid_load)    count_q    <= count_q + XLEN'(1);
         if (misalign_set) misalign_q <= 1'b1;
      end
   end

   assign bus.imem_addr   = pc_p0;
   assign bus.if_valid    = ifid_p1.valid;
   assign bus.if_instr    = ifid_p1.instr;
   assign bus.if_pc       = ifid_p1.pc;
   assign bus.if_pc_plus4 = ifid_p1.pc_plus4;
   assign halted          = (state_q == HALTED);
   assign misalign_err    = misalign_q;
   assign fetch_count     = count_q;

endmodule
